// File: rtl/bsg_dmc_dfi_sequencer.sv
// DFI-initiator command/data sequencer: turns single memory commands into DFI pin,
// write-data and read-enable sequences, and returns read beats to the controller.
module bsg_dmc_dfi_sequencer
  #(parameter int dq_data_width_p = 16
   ,parameter int wl_p            = 3
   ,parameter int rl_p            = 5
   ,parameter int burst_cycles_p  = 4
   ,parameter int cmd_gap_p       = 2
   )
   (input  logic                                              dfi_clk_1x_i
   ,input  logic                                              dfi_rst_i

   ,input  logic                                              cmd_v_i
   ,input  logic [2:0]                                        cmd_i
   ,input  logic [2:0]                                        cmd_bank_i
   ,input  logic [15:0]                                       cmd_addr_i
   ,input  logic [2*dq_data_width_p*burst_cycles_p-1:0]       cmd_wdata_i
   ,input  logic [2*(dq_data_width_p/8)*burst_cycles_p-1:0]   cmd_wmask_i
   ,output logic                                              cmd_ready_o

   ,input  logic                                              init_cke_i
   ,input  logic                                              init_reset_n_i

   ,output logic [2:0]                                        dfi_bank_o
   ,output logic [15:0]                                       dfi_address_o
   ,output logic                                              dfi_cke_o
   ,output logic                                              dfi_cs_n_o
   ,output logic                                              dfi_ras_n_o
   ,output logic                                              dfi_cas_n_o
   ,output logic                                              dfi_we_n_o
   ,output logic                                              dfi_reset_n_o
   ,output logic                                              dfi_odt_o
   ,output logic                                              dfi_wrdata_en_o
   ,output logic [2*dq_data_width_p-1:0]                      dfi_wrdata_o
   ,output logic [2*(dq_data_width_p/8)-1:0]                  dfi_wrdata_mask_o
   ,output logic                                              dfi_rddata_en_o
   ,input  logic [2*dq_data_width_p-1:0]                      dfi_rddata_i
   ,input  logic                                              dfi_rddata_valid_i

   ,output logic                                              rd_data_v_o
   ,output logic [2*dq_data_width_p-1:0]                      rd_data_o
   ,output logic                                              rd_last_o
   ,output logic                                              rd_err_o
   );

    localparam int beat_w_lp  = 2*dq_data_width_p;
    localparam int mask_w_lp  = 2*(dq_data_width_p/8);
    localparam int wdata_w_lp = beat_w_lp*burst_cycles_p;
    localparam int wmask_w_lp = mask_w_lp*burst_cycles_p;

    localparam logic [4:0] wl_lp       = 5'(wl_p);
    localparam logic [4:0] wr_end_lp   = 5'(wl_p + burst_cycles_p);
    localparam logic [4:0] rl_lp       = 5'(rl_p);
    localparam logic [4:0] rd_end_lp   = 5'(rl_p + burst_cycles_p);
    localparam logic [3:0] gap_load_lp = 4'(cmd_gap_p - 1);
    localparam logic [3:0] burst_lp    = 4'(burst_cycles_p);

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5,
        CMD_MRS = 3'd6,
        CMD_ZQ  = 3'd7
    } cmd_e;

    // Returns {cs_n, ras_n, cas_n, we_n} for a command.
    function automatic logic [3:0] pin_encode(input cmd_e cmd);
        logic [3:0] enc;
        enc = 4'b1111;
        case (cmd)
            CMD_ACT: enc = 4'b0011;
            CMD_RD:  enc = 4'b0101;
            CMD_WR:  enc = 4'b0100;
            CMD_PRE: enc = 4'b0010;
            CMD_REF: enc = 4'b0001;
            CMD_MRS: enc = 4'b0000;
            CMD_ZQ:  enc = 4'b0110;
            default: enc = 4'b1111;
        endcase
        return enc;
    endfunction

    cmd_e cmd_l;
    logic accept;

    logic                  ready_q,    ready_d;
    logic [3:0]            gap_q,      gap_d;
    logic [4:0]            cyc_q,      cyc_d;
    logic                  wr_q,       wr_d;
    logic                  rd_q,       rd_d;
    logic [2:0]            beat_cnt_q, beat_cnt_d;
    logic [wdata_w_lp-1:0] wdata_q,    wdata_d;
    logic [wmask_w_lp-1:0] wmask_q,    wmask_d;
    logic [2:0]            bank_q,     bank_d;
    logic [15:0]           addr_q,     addr_d;
    logic [3:0]            pins_q,     pins_d;
    logic                  odt_q,      odt_d;
    logic                  wren_q,     wren_d;
    logic [beat_w_lp-1:0]  wrdata_q,   wrdata_d;
    logic [mask_w_lp-1:0]  wrmask_q,   wrmask_d;
    logic                  rden_q,     rden_d;
    logic                  rdv_q,      rdv_d;
    logic [beat_w_lp-1:0]  rddata_q,   rddata_d;
    logic                  rdlast_q,   rdlast_d;
    logic                  rderr_q,    rderr_d;
    logic                  cke_q;
    logic                  reset_n_q;

    logic [2:0] wr_beat;

    assign cmd_l   = cmd_e'(cmd_i);
    assign accept  = cmd_v_i & ready_q;
    assign wr_beat = 3'(cyc_q - wl_lp);

    always_comb begin
        gap_d      = (gap_q != 4'd0) ? gap_q - 4'd1 : gap_q;
        cyc_d      = cyc_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        beat_cnt_d = beat_cnt_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        bank_d     = bank_q;
        addr_d     = addr_q;
        pins_d     = 4'b1111;
        odt_d      = 1'b0;
        wren_d     = 1'b0;
        wrdata_d   = wrdata_q;
        wrmask_d   = '0;
        rden_d     = 1'b0;
        rdv_d      = 1'b0;
        rddata_d   = rddata_q;
        rdlast_d   = 1'b0;
        rderr_d    = rderr_q;

        // cyc_q counts cycles since the accepting edge; it is 1 while the command is on the pins
        if (wr_q) begin
            odt_d = (cyc_q < wr_end_lp);
            if ((cyc_q >= wl_lp) && (cyc_q < wr_end_lp)) begin
                wren_d   = 1'b1;
                wrdata_d = wdata_q[int'(wr_beat)*beat_w_lp +: beat_w_lp];
                wrmask_d = wmask_q[int'(wr_beat)*mask_w_lp +: mask_w_lp];
            end
            if (cyc_q == wr_end_lp) begin
                wr_d = 1'b0;
            end else begin
                cyc_d = cyc_q + 5'd1;
            end
        end

        if (rd_q) begin
            rden_d = (cyc_q >= rl_lp) && (cyc_q < rd_end_lp);
            if (cyc_q < rd_end_lp) begin
                cyc_d = cyc_q + 5'd1;
            end
        end

        if (dfi_rddata_valid_i) begin
            if (rd_q) begin
                rdv_d    = 1'b1;
                rddata_d = dfi_rddata_i;
                if (({1'b0, beat_cnt_q} + 4'd1) == burst_lp) begin
                    rdlast_d   = 1'b1;
                    beat_cnt_d = 3'd0;
                    rd_d       = 1'b0;
                end else begin
                    beat_cnt_d = beat_cnt_q + 3'd1;
                end
            end else begin
                rderr_d = 1'b1;
            end
        end

        // Accept only happens when idle, so it never collides with the burst updates above
        if (accept) begin
            gap_d  = gap_load_lp;
            pins_d = pin_encode(cmd_l);
            if (cmd_l != CMD_NOP) begin
                bank_d = cmd_bank_i;
                addr_d = cmd_addr_i;
            end
            if (cmd_l == CMD_RD) begin
                rd_d  = 1'b1;
                cyc_d = 5'd1;
            end
            if (cmd_l == CMD_WR) begin
                wr_d    = 1'b1;
                cyc_d   = 5'd1;
                wdata_d = cmd_wdata_i;
                wmask_d = cmd_wmask_i;
                odt_d   = 1'b1;
            end
        end

        ready_d = (gap_d == 4'd0) & ~wr_d & ~rd_d;
    end

    always_ff @(posedge dfi_clk_1x_i or posedge dfi_rst_i) begin
        if (dfi_rst_i) begin
            ready_q    <= 1'b0;
            gap_q      <= 4'd0;
            cyc_q      <= 5'd0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            beat_cnt_q <= 3'd0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            bank_q     <= 3'd0;
            addr_q     <= 16'd0;
            pins_q     <= 4'b1111;
            odt_q      <= 1'b0;
            wren_q     <= 1'b0;
            wrdata_q   <= '0;
            wrmask_q   <= '0;
            rden_q     <= 1'b0;
            rdv_q      <= 1'b0;
            rddata_q   <= '0;
            rdlast_q   <= 1'b0;
            rderr_q    <= 1'b0;
            cke_q      <= 1'b0;
            reset_n_q  <= 1'b0;
        end else begin
            ready_q    <= ready_d;
            gap_q      <= gap_d;
            cyc_q      <= cyc_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            beat_cnt_q <= beat_cnt_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            bank_q     <= bank_d;
            addr_q     <= addr_d;
            pins_q     <= pins_d;
            odt_q      <= odt_d;
            wren_q     <= wren_d;
            wrdata_q   <= wrdata_d;
            wrmask_q   <= wrmask_d;
            rden_q     <= rden_d;
            rdv_q      <= rdv_d;
            rddata_q   <= rddata_d;
            rdlast_q   <= rdlast_d;
            rderr_q    <= rderr_d;
            cke_q      <= init_cke_i;
            reset_n_q  <= init_reset_n_i;
        end
    end

    assign cmd_ready_o       = ready_q;
    assign dfi_bank_o        = bank_q;
    assign dfi_address_o     = addr_q;
    assign dfi_cke_o         = cke_q;
    assign dfi_cs_n_o        = pins_q[3];
    assign dfi_ras_n_o       = pins_q[2];
    assign dfi_cas_n_o       = pins_q[1];
    assign dfi_we_n_o        = pins_q[0];
    assign dfi_reset_n_o     = reset_n_q;
    assign dfi_odt_o         = odt_q;
    assign dfi_wrdata_en_o   = wren_q;
    assign dfi_wrdata_o      = wrdata_q;
    assign dfi_wrdata_mask_o = wrmask_q;
    assign dfi_rddata_en_o   = rden_q;
    assign rd_data_v_o       = rdv_q;
    assign rd_data_o         = rddata_q;
    assign rd_last_o         = rdlast_q;
    assign rd_err_o          = rderr_q;

endmodule

// File: tb/tb_bsg_dmc_dfi_sequencer.sv
// Randomized self-checking bench for bsg_dmc_dfi_sequencer; expectations come from
// per-command timing windows computed relative to the accept cycle.
module tb_bsg_dmc_dfi_sequencer;
  localparam int DQ  = 16;
  localparam int WL  = 3;
  localparam int RL  = 5;
  localparam int BC  = 4;
  localparam int GAP = 2;
  localparam int BW  = 2*DQ;
  localparam int MW  = 2*(DQ/8);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmd_v;
  logic [2:0] cmd, bank;
  logic [15:0] addr;
  logic [BW*BC-1:0] wdata;
  logic [MW*BC-1:0] wmask;
  logic cke_in, rstn_in;
  logic [BW-1:0] rddata_in;
  logic rdvalid_in;

  logic cmd_ready_o, dfi_cke_o, dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o;
  logic dfi_reset_n_o, dfi_odt_o, dfi_wrdata_en_o, dfi_rddata_en_o;
  logic [2:0] dfi_bank_o;
  logic [15:0] dfi_address_o;
  logic [BW-1:0] dfi_wrdata_o, rd_data_o;
  logic [MW-1:0] dfi_wrdata_mask_o;
  logic rd_data_v_o, rd_last_o, rd_err_o;

  int checks = 0;
  int errors = 0;

  // Reference state: last addressed bank/address, last written beat, sticky error
  logic [2:0]  m_bank;
  logic [15:0] m_addr;
  logic [BW-1:0] m_wbeat;
  logic m_err;

  wire [7:0] ctl_obs = {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o,
                        dfi_wrdata_en_o, dfi_odt_o, dfi_rddata_en_o, cmd_ready_o};

  bsg_dmc_dfi_sequencer #(
    .dq_data_width_p(DQ), .wl_p(WL), .rl_p(RL), .burst_cycles_p(BC), .cmd_gap_p(GAP)
  ) dut (
    .dfi_clk_1x_i(clk), .dfi_rst_i(rst),
    .cmd_v_i(cmd_v), .cmd_i(cmd), .cmd_bank_i(bank), .cmd_addr_i(addr),
    .cmd_wdata_i(wdata), .cmd_wmask_i(wmask), .cmd_ready_o(cmd_ready_o),
    .init_cke_i(cke_in), .init_reset_n_i(rstn_in),
    .dfi_bank_o(dfi_bank_o), .dfi_address_o(dfi_address_o), .dfi_cke_o(dfi_cke_o),
    .dfi_cs_n_o(dfi_cs_n_o), .dfi_ras_n_o(dfi_ras_n_o), .dfi_cas_n_o(dfi_cas_n_o),
    .dfi_we_n_o(dfi_we_n_o), .dfi_reset_n_o(dfi_reset_n_o), .dfi_odt_o(dfi_odt_o),
    .dfi_wrdata_en_o(dfi_wrdata_en_o), .dfi_wrdata_o(dfi_wrdata_o),
    .dfi_wrdata_mask_o(dfi_wrdata_mask_o), .dfi_rddata_en_o(dfi_rddata_en_o),
    .dfi_rddata_i(rddata_in), .dfi_rddata_valid_i(rdvalid_in),
    .rd_data_v_o(rd_data_v_o), .rd_data_o(rd_data_o), .rd_last_o(rd_last_o),
    .rd_err_o(rd_err_o)
  );

  always #5 clk = ~clk;

  // {cs_n, ras_n, cas_n, we_n} required on the pins for each command code
  function automatic logic [3:0] pins_of(input logic [2:0] c);
    logic [3:0] p;
    case (c)
      3'd1: p = 4'b0011;
      3'd2: p = 4'b0101;
      3'd3: p = 4'b0100;
      3'd4: p = 4'b0010;
      3'd5: p = 4'b0001;
      3'd6: p = 4'b0000;
      3'd7: p = 4'b0110;
      default: p = 4'b1111;
    endcase
    return p;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (cmd_ready_o !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready: ready=%b after %0d cycles, required 1", cmd_ready_o, n);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (ctl_obs !== 8'hF0) begin
      errors++; $display("FAIL reset_ctl: got %b required %b", ctl_obs, 8'hF0);
    end
    checks++;
    if ({dfi_bank_o, dfi_address_o, dfi_wrdata_o, dfi_wrdata_mask_o, rd_data_o} !== '0) begin
      errors++; $display("FAIL reset_data: got %h required 0",
                         {dfi_bank_o, dfi_address_o, dfi_wrdata_o, dfi_wrdata_mask_o, rd_data_o});
    end
    checks++;
    if ({dfi_cke_o, dfi_reset_n_o, rd_data_v_o, rd_last_o, rd_err_o} !== 5'b0) begin
      errors++; $display("FAIL reset_misc: got %b required 00000",
                         {dfi_cke_o, dfi_reset_n_o, rd_data_v_o, rd_last_o, rd_err_o});
    end
    cke_in = 1'b1; rstn_in = 1'b1; rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready_o !== 1'b0) begin
      errors++; $display("FAIL reset_ready_before_edge: got %b required 0", cmd_ready_o);
    end
    @(negedge clk);
    checks++;
    if ({cmd_ready_o, dfi_cke_o, dfi_reset_n_o, rd_err_o} !== 4'b1110) begin
      errors++; $display("FAIL reset_release: ready/cke/reset_n/err got %b required 1110",
                         {cmd_ready_o, dfi_cke_o, dfi_reset_n_o, rd_err_o});
    end
    m_bank = '0; m_addr = '0; m_wbeat = '0; m_err = 1'b0;
  endtask

  task automatic test_simple_cmds(input int n);
    logic [2:0] c, b;
    logic [15:0] a;
    logic [7:0] exp_ctl;
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        c = 3'd1; b = 3'd2; a = 16'h1234;
      end else begin
        c = 3'($urandom_range(0, 7));
        if (c == 3'd2 || c == 3'd3) c = c + 3'd2;
        b = 3'($urandom); a = 16'($urandom);
      end
      wait_ready();
      cmd_v = 1'b1; cmd = c; bank = b; addr = a;
      for (int k = 1; k <= GAP; k++) begin
        @(negedge clk);
        if (k == 1) begin
          cmd_v = 1'b0;
          if (c != 3'd0) begin m_bank = b; m_addr = a; end
        end
        exp_ctl = {(k == 1) ? pins_of(c) : 4'hF, 3'b000, (k >= GAP)};
        checks++;
        if (ctl_obs !== exp_ctl) begin
          errors++; $display("FAIL cmd%0d_ctl k=%0d: got %b required %b", c, k, ctl_obs, exp_ctl);
        end
        checks++;
        if ({dfi_bank_o, dfi_address_o} !== {m_bank, m_addr}) begin
          errors++; $display("FAIL cmd%0d_bank_addr k=%0d: got %h required %h", c, k,
                             {dfi_bank_o, dfi_address_o}, {m_bank, m_addr});
        end
      end
    end
  endtask

  task automatic test_write(input bit plan, input int abort_k);
    logic [BW-1:0] wb [BC];
    logic [MW-1:0] mb [BC];
    logic [MW-1:0] exp_mask;
    logic [2:0] b;
    logic [15:0] a;
    logic [7:0] exp_ctl;
    bit en, aborted;
    aborted = 1'b0;
    for (int i = 0; i < BC; i++) begin
      if (plan) begin
        wb[i] = BW'(32'hA5A5_0000 + 32'(i) * 32'h1111);
        mb[i] = (i == 2) ? MW'(3) : '0;
      end else begin
        wb[i] = BW'($urandom);
        mb[i] = MW'($urandom);
      end
      wdata[i*BW +: BW] = wb[i];
      wmask[i*MW +: MW] = mb[i];
    end
    b = 3'($urandom); a = 16'($urandom);
    wait_ready();
    cmd_v = 1'b1; cmd = 3'd3; bank = b; addr = a;
    for (int k = 1; k <= WL + BC + 2 && !aborted; k++) begin
      @(negedge clk);
      if (k == 1) begin cmd_v = 1'b0; m_bank = b; m_addr = a; end
      en = (k >= WL + 1) && (k <= WL + BC);
      exp_mask = '0;
      if (en) begin
        m_wbeat  = wb[k-WL-1];
        exp_mask = mb[k-WL-1];
      end
      exp_ctl = {(k == 1) ? pins_of(3'd3) : 4'hF, en, (k <= WL + BC), 1'b0,
                 (k >= GAP) && (k >= WL + BC + 1)};
      checks++;
      if (ctl_obs !== exp_ctl) begin
        errors++; $display("FAIL wr_ctl k=%0d: got %b required %b", k, ctl_obs, exp_ctl);
      end
      checks++;
      if ({dfi_wrdata_o, dfi_wrdata_mask_o} !== {m_wbeat, exp_mask}) begin
        errors++; $display("FAIL wr_data k=%0d: got %h/%h required %h/%h", k,
                           dfi_wrdata_o, dfi_wrdata_mask_o, m_wbeat, exp_mask);
      end
      checks++;
      if ({dfi_bank_o, dfi_address_o, rd_data_v_o} !== {m_bank, m_addr, 1'b0}) begin
        errors++; $display("FAIL wr_bank_addr k=%0d: got %h required %h", k,
                           {dfi_bank_o, dfi_address_o, rd_data_v_o}, {m_bank, m_addr, 1'b0});
      end
      if (k == abort_k) begin
        aborted = 1'b1;
        rst = 1'b1;
      end
    end
  endtask

  task automatic test_read(input bit plan);
    int bc [BC];
    logic [BW-1:0] rb [BC];
    logic [BW-1:0] ed;
    logic [2:0] b;
    logic [15:0] a;
    logic [7:0] exp_ctl;
    bit ev;
    int off, lastc;
    off = plan ? RL + 5 : RL + 1 + int'($urandom_range(0, 6));
    for (int i = 0; i < BC; i++) begin
      bc[i] = off;
      rb[i] = plan ? BW'(32'hC0DE_0000 + 32'(i)) : BW'($urandom);
      off = off + 1 + (plan ? 0 : int'($urandom_range(0, 2)));
    end
    lastc = bc[BC-1];
    b = 3'($urandom); a = 16'($urandom);
    wait_ready();
    cmd_v = 1'b1; cmd = 3'd2; bank = b; addr = a;
    for (int k = 1; k <= lastc + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin cmd_v = 1'b0; m_bank = b; m_addr = a; end
      ev = 1'b0; ed = '0;
      for (int i = 0; i < BC; i++) begin
        if (bc[i] == k - 1) begin ev = 1'b1; ed = rb[i]; end
      end
      exp_ctl = {(k == 1) ? pins_of(3'd2) : 4'hF, 2'b00, (k >= RL + 1) && (k <= RL + BC),
                 (k >= GAP) && (k >= lastc + 1)};
      checks++;
      if (ctl_obs !== exp_ctl) begin
        errors++; $display("FAIL rd_ctl k=%0d: got %b required %b", k, ctl_obs, exp_ctl);
      end
      checks++;
      if ({rd_data_v_o, rd_last_o, rd_err_o} !== {ev, (k - 1 == lastc), m_err}) begin
        errors++; $display("FAIL rd_flags k=%0d: v/last/err got %b required %b", k,
                           {rd_data_v_o, rd_last_o, rd_err_o}, {ev, (k - 1 == lastc), m_err});
      end
      if (ev) begin
        checks++;
        if (rd_data_o !== ed) begin
          errors++; $display("FAIL rd_data k=%0d: got %h required %h", k, rd_data_o, ed);
        end
      end
      checks++;
      if ({dfi_bank_o, dfi_address_o} !== {m_bank, m_addr}) begin
        errors++; $display("FAIL rd_bank_addr k=%0d: got %h required %h", k,
                           {dfi_bank_o, dfi_address_o}, {m_bank, m_addr});
      end
      rdvalid_in = 1'b0;
      rddata_in  = BW'($urandom);
      for (int i = 0; i < BC; i++) begin
        if (bc[i] == k) begin rdvalid_in = 1'b1; rddata_in = rb[i]; end
      end
    end
    rdvalid_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [2:0] lc [3];
    logic [2:0] lb [3];
    logic [15:0] la [3];
    logic [2:0] acc_cmd;
    logic [7:0] exp_ctl;
    bit rdy;
    int acc_k, cur;
    lc[0] = 3'd0; lc[1] = 3'd4; lc[2] = 3'd5;
    for (int i = 0; i < 3; i++) begin lb[i] = 3'($urandom); la[i] = 16'($urandom); end
    wait_ready();
    cmd_v = 1'b1; cmd = lc[0]; bank = lb[0]; addr = la[0];
    acc_k = 0; acc_cmd = lc[0]; cur = 1;
    for (int k = 1; k <= 3*GAP + 1; k++) begin
      @(negedge clk);
      rdy = (k - acc_k >= GAP);
      exp_ctl = {(k == acc_k + 1) ? pins_of(acc_cmd) : 4'hF, 3'b000, rdy};
      checks++;
      if (ctl_obs !== exp_ctl) begin
        errors++; $display("FAIL b2b_ctl k=%0d: got %b required %b", k, ctl_obs, exp_ctl);
      end
      checks++;
      if ({dfi_bank_o, dfi_address_o} !== {m_bank, m_addr}) begin
        errors++; $display("FAIL b2b_bank_addr k=%0d: got %h required %h", k,
                           {dfi_bank_o, dfi_address_o}, {m_bank, m_addr});
      end
      if (cur < 3) begin
        cmd_v = 1'b1; cmd = lc[cur]; bank = lb[cur]; addr = la[cur];
        if (rdy) begin
          acc_k = k; acc_cmd = lc[cur];
          if (lc[cur] != 3'd0) begin m_bank = lb[cur]; m_addr = la[cur]; end
          cur++;
        end
      end else begin
        cmd_v = 1'b0;
      end
    end
    cmd_v = 1'b0;
  endtask

  task automatic test_orphan();
    checks++;
    if (rd_err_o !== 1'b0) begin
      errors++; $display("FAIL orphan_pre: rd_err got %b required 0", rd_err_o);
    end
    for (int k = 0; k < 6; k++) begin
      rdvalid_in = (k < 2);
      rddata_in  = BW'($urandom);
      @(negedge clk);
      m_err = 1'b1;
      checks++;
      if ({rd_data_v_o, rd_last_o, rd_err_o} !== 3'b001) begin
        errors++; $display("FAIL orphan k=%0d: v/last/err got %b required 001", k,
                           {rd_data_v_o, rd_last_o, rd_err_o});
      end
      checks++;
      if (ctl_obs !== 8'hF1) begin
        errors++; $display("FAIL orphan_ctl k=%0d: got %b required %b", k, ctl_obs, 8'hF1);
      end
    end
    rdvalid_in = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    test_write(1'b0, WL + 2);
    #1;
    checks++;
    if (ctl_obs !== 8'hF0) begin
      errors++; $display("FAIL midrst_ctl: got %b required %b", ctl_obs, 8'hF0);
    end
    checks++;
    if ({dfi_bank_o, dfi_address_o, dfi_wrdata_o, dfi_wrdata_mask_o, rd_data_o} !== '0) begin
      errors++; $display("FAIL midrst_data: got %h required 0",
                         {dfi_bank_o, dfi_address_o, dfi_wrdata_o, dfi_wrdata_mask_o, rd_data_o});
    end
    checks++;
    if ({dfi_cke_o, dfi_reset_n_o, rd_data_v_o, rd_last_o, rd_err_o} !== 5'b0) begin
      errors++; $display("FAIL midrst_misc: got %b required 00000",
                         {dfi_cke_o, dfi_reset_n_o, rd_data_v_o, rd_last_o, rd_err_o});
    end
    m_bank = '0; m_addr = '0; m_wbeat = '0; m_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready_o, dfi_cke_o, dfi_reset_n_o, rd_err_o, dfi_wrdata_en_o} !== 5'b11100) begin
      errors++; $display("FAIL midrst_release: got %b required 11100",
                         {cmd_ready_o, dfi_cke_o, dfi_reset_n_o, rd_err_o, dfi_wrdata_en_o});
    end
    test_read(1'b0);
  endtask

  initial begin
    cmd_v = 1'b0; cmd = '0; bank = '0; addr = '0; wdata = '0; wmask = '0;
    cke_in = 1'b0; rstn_in = 1'b0; rddata_in = '0; rdvalid_in = 1'b0;
    m_bank = '0; m_addr = '0; m_wbeat = '0; m_err = 1'b0;
    test_reset();
    test_simple_cmds(8);
    test_write(1'b1, 0);
    for (int i = 0; i < 3; i++) test_write(1'b0, 0);
    test_read(1'b1);
    for (int i = 0; i < 3; i++) test_read(1'b0);
    test_back_to_back();
    test_orphan();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
